inv_key_expansion: RTL
======================

# inv_key_expansion

Sequential AES-128 inverse key schedule for the decryption datapath. Takes the cipher key, runs the forward schedule once to reach the round-10 key, then streams round keys 10 down to 0 over a valid/ready interface. Each step back is one inverse expansion step per accepted beat, so the decrypt rounds consume keys in their natural order without an 11-entry key store. Reuses the existing SubWord, RotWord and Rcon blocks.

## Interface
- size, 128: key width; only 128 is supported, and any other value must fail elaboration.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_in  input  size  cipher key, with word 0 at [127:96].
- key_load  input  1  start pulse; samples key_in when busy=0.
- busy  output  1  high from an accepted load until round key 0 is accepted.
- rk_out  output  size  current round key.
- rk_round  output  4  round index of rk_out, 10..0.
- rk_valid  output  1  rk_out/rk_round valid.
- rk_ready  input  1  consumer accepts the beat when rk_valid & rk_ready.

## Operation
- States:
  - IDLE: busy=0, rk_valid=0. key_load=1 captures key_in into the key register, sets rc=1 and goes to EXPAND.
  - EXPAND: each cycle applies one forward step using Rcon(rc), then increments rc. After the step with rc=10, goes to EMIT with rk_round=10.
  - EMIT: rk_valid=1. On handshake with rk_round>0, replaces the register with the previous round key and decrements rk_round. On handshake with rk_round=0, goes to IDLE.
- Forward step, key {a0,a1,a2,a3} to {b0..b3}:
  - b0 = a0 ^ SubWord(RotWord(a3)) ^ Rcon(rc)
  - b1 = b0 ^ a1, b2 = b1 ^ a2, b3 = b2 ^ a3
- Inverse step, round-r key {a0..a3} to round r-1 key {b0..b3}:
  - b3 = a3 ^ a2, b2 = a2 ^ a1, b1 = a1 ^ a0
  - b0 = a0 ^ SubWord(RotWord(b3)) ^ Rcon(r)
  - Rcon index is the current rk_round, never r-1.
- Rcon(i), i = 1..10: 01,02,04,08,10,20,40,80,1b,36 in the top byte, zeros below.
- All XORs are 32-bit and bitwise, with no carries.
- One shared SubWord instance is acceptable; EXPAND and EMIT never step in the same cycle.
- key_load while busy=1 is ignored; the in-flight schedule is unaffected.
- rk_ready is don't-care while rk_valid=0.

## Timing
- Reset (async assert, sync release): state=IDLE, busy=0, rk_valid=0, rk_out=0, rk_round=0, rc=0.
- Load at edge 0. busy=1 from edge 0.
- EXPAND steps occur at edges 1..10.
- rk_valid=1 and rk_round=10 after edge 10. Latency is 10 cycles from the load edge to the first valid key.
- rk_out/rk_round hold stable while rk_valid & !rk_ready.
- Back-to-back ready gives one key per cycle: 11 beats in 11 cycles.
- Handshake of round 0 at edge n: rk_valid=0 and busy=0 after edge n. rk_out retains the round-0 key.
- A new key_load is accepted no earlier than the first cycle with busy=0. A load asserted in the same cycle as the round-0 handshake is ignored.
- Reset mid-EXPAND or mid-EMIT forces reset values immediately; no partial beat completes.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - first beat after 10 cycles: rk_round=10, rk_out=d014f9a8c9ee2589e13f0cc8b6630ca6
  - second beat: round 9 = ac7766f319fadc2128d12941575c006e
  - round-1 beat: a0fafe1788542cb123a339392a6c7605
  - last beat: round 0 = the key itself
  - then busy=0 next cycle.
- Same key, rk_ready toggled randomly:
  - the 11 keys are identical and in the same order
  - outputs are stable during stalls
  - no beat is dropped or duplicated.
- All-zero key: round 10 = b4ef5bcb3e92e21123e951cf6f8f188e, round 0 = 0.
- key_load=1 with key ff..ff during EXPAND and during EMIT: ignored, and the stream matches the original key.
- rst_n low during EMIT at round 5: rk_valid, busy, rk_out and rk_round are 0 immediately. A new load then yields a correct full stream.
- key_load asserted in the same cycle as the round-0 handshake: ignored. The same pulse one cycle later starts a new schedule.

Source files
------------

// File: rtl/inv_key_expansion.sv
// AES-128 inverse key schedule: expands the cipher key forward to round 10, then
// streams round keys 10..0 over valid/ready, stepping back one round per beat.
module inv_key_expansion #(
    parameter int unsigned size = 128
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [size-1:0] key_in,
    input  logic            key_load,
    output logic            busy,
    output logic [size-1:0] rk_out,
    output logic [3:0]      rk_round,
    output logic            rk_valid,
    input  logic            rk_ready
);

    localparam int unsigned WW = 32;
    localparam int unsigned RW = 4;
    localparam logic [RW-1:0] LAST_ROUND = RW'(10);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXPAND = 2'd1;
    localparam logic [1:0] S_EMIT   = 2'd2;

    if (size != 128) begin : g_size_check
        $error("inv_key_expansion: only size=128 is supported");
    end

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [WW-1:0] sub_word(input logic [WW-1:0] w);
        logic [WW-1:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = SBOX[w[8*i +: 8]];
        end
        return r;
    endfunction

    function automatic logic [WW-1:0] rot_word(input logic [WW-1:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [WW-1:0] rcon(input logic [RW-1:0] idx);
        logic [7:0] b;
        case (idx)
            4'd1:    b = 8'h01;
            4'd2:    b = 8'h02;
            4'd3:    b = 8'h04;
            4'd4:    b = 8'h08;
            4'd5:    b = 8'h10;
            4'd6:    b = 8'h20;
            4'd7:    b = 8'h40;
            4'd8:    b = 8'h80;
            4'd9:    b = 8'h1b;
            4'd10:   b = 8'h36;
            default: b = 8'h00;
        endcase
        return {b, 24'h000000};
    endfunction

    logic [1:0]      state_q, state_d;
    logic [size-1:0] key_q, key_d;
    logic [RW-1:0]   rc_q, rc_d;
    logic [RW-1:0]   round_q, round_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;

    logic [WW-1:0]   a0, a1, a2, a3;
    logic [WW-1:0]   inv_b1, inv_b2, inv_b3;
    logic [WW-1:0]   sw_in, g_word;
    logic [RW-1:0]   rc_idx;
    logic [WW-1:0]   fwd0, fwd1, fwd2, fwd3;
    logic [size-1:0] fwd_key, inv_key;
    logic            emit_sel;

    // Shared SubWord path: EXPAND feeds a3 with rc, EMIT feeds b3 with the current round.
    always_comb begin
        a0       = key_q[127:96];
        a1       = key_q[95:64];
        a2       = key_q[63:32];
        a3       = key_q[31:0];
        emit_sel = (state_q == S_EMIT);
        inv_b3   = a3 ^ a2;
        inv_b2   = a2 ^ a1;
        inv_b1   = a1 ^ a0;
        sw_in    = emit_sel ? inv_b3 : a3;
        rc_idx   = emit_sel ? round_q : rc_q;
        g_word   = sub_word(rot_word(sw_in)) ^ rcon(rc_idx);
        fwd0     = a0 ^ g_word;
        fwd1     = fwd0 ^ a1;
        fwd2     = fwd1 ^ a2;
        fwd3     = fwd2 ^ a3;
        fwd_key  = {fwd0, fwd1, fwd2, fwd3};
        inv_key  = {a0 ^ g_word, inv_b1, inv_b2, inv_b3};
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        rc_d    = rc_q;
        round_d = round_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                if (key_load) begin
                    key_d   = key_in;
                    rc_d    = RW'(1);
                    busy_d  = 1'b1;
                    state_d = S_EXPAND;
                end
            end
            S_EXPAND: begin
                key_d = fwd_key;
                rc_d  = rc_q + RW'(1);
                if (rc_q == LAST_ROUND) begin
                    rc_d    = '0;
                    round_d = LAST_ROUND;
                    valid_d = 1'b1;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (rk_ready) begin
                    if (round_q != '0) begin
                        key_d   = inv_key;
                        round_d = round_q - RW'(1);
                    end else begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            key_q   <= '0;
            rc_q    <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            rc_q    <= rc_d;
            round_q <= round_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign rk_out   = key_q;
    assign rk_round = round_q;
    assign rk_valid = valid_q;

endmodule
